alu_seq_n: RTL and testbench

Parametrised-width registered ALU for the next CPU datapath generation. Adds a valid/ready handshake on both sides, a full NZCV flag set, single-cycle barrel shifts and a multi-cycle shift-add multiplier. It sits between the register file read stage and the writeback mux. A single output register provides backpressure.

---
 rtl/alu_seq_n_pkg.sv | 45 ++++
 rtl/alu_seq_n_if.sv | 34 +++
 rtl/full_adder_n.sv | 25 ++
 rtl/alu_seq_n.sv | 188 ++++++++++++++++++
 tb/tb_alu_seq_n.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_n_pkg.sv
// Shared definitions for the alu_seq_n block.
//   - 4-bit opcode encodings (anything not listed here is illegal)
//   - control FSM state encoding
//   - bit positions of the packed NZCV flag word
//   - pack_flags(): assemble a flag word from its four bits
package alu_seq_n_pkg;

    localparam logic [3:0] OP_TRANSFER = 4'h0;
    localparam logic [3:0] OP_INC      = 4'h1;
    localparam logic [3:0] OP_ADD      = 4'h2;
    localparam logic [3:0] OP_ADDC     = 4'h3;
    localparam logic [3:0] OP_SUB      = 4'h4;
    localparam logic [3:0] OP_DEC      = 4'h5;
    localparam logic [3:0] OP_AND      = 4'h6;
    localparam logic [3:0] OP_OR       = 4'h7;
    localparam logic [3:0] OP_XOR      = 4'h8;
    localparam logic [3:0] OP_NOT      = 4'h9;
    localparam logic [3:0] OP_SHL      = 4'hA;
    localparam logic [3:0] OP_SHR      = 4'hB;
    localparam logic [3:0] OP_MUL      = 4'hC;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    typedef logic [3:0] flags_t;

    function automatic flags_t pack_flags(input logic n, input logic z,
                                          input logic c, input logic v);
        flags_t f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_n_if.sv
// Handshake/bus bundle for alu_seq_n.
//   master: producer/consumer side (drives operands, in_valid, out_ready)
//   slave : the ALU (drives in_ready, out_valid, result, result_hi, flags, err)
interface alu_seq_n_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             err;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, result, result_hi,
               flag_n, flag_z, flag_c, flag_v, err
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, result, result_hi,
               flag_n, flag_z, flag_c, flag_v, err
    );
endinterface

// File: rtl/full_adder_n.sv
// Combinational WIDTH-bit ripple-carry adder.
//   a, b, cin -> sum, cout
module full_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[WIDTH];
endmodule

// File: rtl/alu_seq_n.sv
// Registered ALU with valid/ready on both sides.
//   clk, rst : clock and synchronous active-high reset
//   bus      : alu_seq_n_if.slave (operands/opcode in, result/flags/err out)
// Single-cycle ops land in the output register one edge after accept.
// MUL runs a WIDTH-iteration shift-add loop on the shared ripple adder.
module alu_seq_n
    import alu_seq_n_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    alu_seq_n_if.slave  bus
);
    localparam int               CNT_W = $clog2(WIDTH + 1);
    localparam int               SH_W  = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] W_B   = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mpl_q, mpl_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    flags_t             flags_q, flags_d;
    logic               err_q, err_d;

    logic               accept, drain, is_mul;
    logic [WIDTH-1:0]   add_a, add_b, add_sum;
    logic               add_ci, add_co;
    logic [SH_W-1:0]    shamt;
    logic [WIDTH:0]     shl_w, shr_w;
    logic [WIDTH-1:0]   op_res;
    logic               op_c, op_v, op_err;
    logic [WIDTH-1:0]   acc_step, mpl_step;

    assign drain        = out_valid_q && bus.out_ready;
    assign bus.in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_mul       = MUL_EN && (bus.op == OP_MUL);

    // Shifts keep one guard bit so the last bit shifted out falls into it;
    // with a zero amount the guard stays 0.
    assign shamt = SH_W'(bus.b % W_B);
    assign shl_w = {1'b0, bus.a} << shamt;
    assign shr_w = {bus.a, 1'b0} >> shamt;

    // Adder is owned by the MUL loop while BUSY, otherwise by the opcode.
    always_comb begin
        add_a  = bus.a;
        add_b  = '0;
        add_ci = 1'b0;
        if (state_q == BUSY) begin
            add_a = acc_q;
            add_b = mpl_q[0] ? mcand_q : '0;
        end else begin
            case (bus.op)
                OP_INC:  add_ci = 1'b1;
                OP_ADD:  add_b  = bus.b;
                OP_ADDC: begin add_b = bus.b;  add_ci = bus.cin; end
                OP_SUB:  begin add_b = ~bus.b; add_ci = 1'b1;    end
                OP_DEC:  add_b  = '1;
                default: ;
            endcase
        end
    end

    full_adder_n #(.WIDTH(WIDTH)) u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_ci),
        .sum  (add_sum),
        .cout (add_co)
    );

    // One shift-add step: {acc, mplier} <= {cout, sum, mplier} >> 1
    assign acc_step = {add_co, add_sum[WIDTH-1:1]};
    assign mpl_step = {add_sum[0], mpl_q[WIDTH-1:1]};

    // Single-cycle result; MUL lands in default only when it is disabled.
    always_comb begin
        op_res = '0;
        op_c   = 1'b0;
        op_v   = 1'b0;
        op_err = 1'b0;
        case (bus.op)
            OP_TRANSFER: op_res = bus.a;
            OP_INC, OP_ADD, OP_ADDC, OP_SUB, OP_DEC: begin
                op_res = add_sum;
                op_c   = add_co;
                op_v   = (bus.a[WIDTH-1] == add_b[WIDTH-1]) &&
                         (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: op_res = bus.a & bus.b;
            OP_OR:  op_res = bus.a | bus.b;
            OP_XOR: op_res = bus.a ^ bus.b;
            OP_NOT: op_res = ~bus.a;
            OP_SHL: begin op_res = shl_w[WIDTH-1:0]; op_c = shl_w[WIDTH]; end
            OP_SHR: begin op_res = shr_w[WIDTH:1];   op_c = shr_w[0];     end
            default: op_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mpl_d       = mpl_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !drain;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mul) begin
                    state_d = BUSY;
                    mcand_d = bus.a;
                    mpl_d   = bus.b;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    result_d    = op_res;
                    result_hi_d = '0;
                    flags_d     = op_err ? '0 :
                                  pack_flags(op_res[WIDTH-1], op_res == '0, op_c, op_v);
                    err_d       = op_err;
                end
            end
            BUSY: begin
                acc_d = acc_step;
                mpl_d = mpl_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    result_d    = mpl_step;
                    result_hi_d = acc_step;
                    flags_d     = pack_flags(mpl_step[WIDTH-1], mpl_step == '0,
                                             |acc_step, 1'b0);
                    err_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mpl_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mpl_q       <= mpl_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.flag_n    = flags_q[FLAG_N];
    assign bus.flag_z    = flags_q[FLAG_Z];
    assign bus.flag_c    = flags_q[FLAG_C];
    assign bus.flag_v    = flags_q[FLAG_V];
    assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_seq_n.sv
module tb_alu_seq_n;
    import alu_seq_n_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_n_if #(.WIDTH(W)) bus();

    alu_seq_n #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [3:0]   nzcv;
        logic         err;
    } exp_t;

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic ci);
        exp_t         e;
        int           ua, ub, sa, sb, s, ss, amt;
        logic         c, v, arith;
        logic [W-1:0] av;
        int unsigned  p;
        ua = int'(a);  ub = int'(b);
        sa = int'($signed(a));  sb = int'($signed(b));
        av = a;  s = 0;  ss = 0;  c = 1'b0;  v = 1'b0;  arith = 1'b0;
        e.res = '0;  e.hi = '0;  e.err = 1'b0;  e.nzcv = '0;
        case (op)
            OP_TRANSFER: e.res = a;
            OP_INC:  begin s = ua + 1;             ss = sa + 1;             arith = 1; c = (s >= 2**W); end
            OP_ADD:  begin s = ua + ub;            ss = sa + sb;            arith = 1; c = (s >= 2**W); end
            OP_ADDC: begin s = ua + ub + int'(ci); ss = sa + sb + int'(ci); arith = 1; c = (s >= 2**W); end
            OP_SUB:  begin s = ua - ub;            ss = sa - sb;            arith = 1; c = (ua >= ub);  end
            OP_DEC:  begin s = ua - 1;             ss = sa - 1;             arith = 1; c = (ua != 0);   end
            OP_AND:  e.res = a & b;
            OP_OR:   e.res = a | b;
            OP_XOR:  e.res = a ^ b;
            OP_NOT:  e.res = ~a;
            OP_SHL: begin
                amt   = ub % W;
                e.res = a << amt;
                c     = (amt == 0) ? 1'b0 : av[W - amt];
            end
            OP_SHR: begin
                amt   = ub % W;
                e.res = a >> amt;
                c     = (amt == 0) ? 1'b0 : av[amt - 1];
            end
            OP_MUL: begin
                p     = ua * ub;
                e.res = p[W-1:0];
                e.hi  = p[2*W-1:W];
                c     = (e.hi != 0);
            end
            default: e.err = 1'b1;
        endcase
        if (arith) begin
            e.res = W'(s);
            v     = (ss > 2**(W-1) - 1) || (ss < -(2**(W-1)));
        end
        if (!e.err) e.nzcv = {e.res[W-1], e.res == '0, c, v};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] nzcv_now();
        return {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
    endfunction

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".result"},    32'(bus.result),    32'(e.res));
        chk({tag, ".result_hi"}, 32'(bus.result_hi), 32'(e.hi));
        chk({tag, ".nzcv"},      32'(nzcv_now()),    32'(e.nzcv));
        chk({tag, ".err"},       32'(bus.err),       32'(e.err));
    endtask

    // Called at a negedge with out_ready=1; any pending result drains on the
    // same edge the new op is accepted. Returns at the negedge where the new
    // result is visible.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t e;
        e = model(op, a, b, ci);
        bus.in_valid = 1'b1;  bus.op = op;  bus.a = a;  bus.b = b;  bus.cin = ci;
        #1;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (op == OP_MUL) begin
            for (int k = 0; k < W; k++) begin
                chk({tag, ".busy_in_ready"},  32'(bus.in_ready),  32'd0);
                chk({tag, ".busy_out_valid"}, 32'(bus.out_valid), 32'd0);
                @(negedge clk);
            end
        end
        chk_out(tag, e);
    endtask

    initial begin
        exp_t e_add, e_xor;
        logic [3:0] rop;

        rst = 1'b1;
        bus.in_valid = 1'b0;  bus.op = '0;  bus.a = '0;  bus.b = '0;
        bus.cin = 1'b0;  bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.result",    32'(bus.result),    32'd0);
        chk("rst.result_hi", 32'(bus.result_hi), 32'd0);
        chk("rst.nzcv",      32'(nzcv_now()),    32'd0);
        chk("rst.err",       32'(bus.err),       32'd0);
        chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
        rst = 1'b0;

        // Directed cases
        run_op("add_ovf",  OP_ADD, 8'h7F, 8'h01, 1'b0);
        run_op("sub_neg",  OP_SUB, 8'h05, 8'h07, 1'b0);
        run_op("sub_zero", OP_SUB, 8'h07, 8'h07, 1'b0);
        run_op("mul_ff",   OP_MUL, 8'hFF, 8'hFF, 1'b0);
        run_op("mul_0f11", OP_MUL, 8'h0F, 8'h11, 1'b0);
        run_op("shl",      OP_SHL, 8'h81, 8'h01, 1'b0);
        run_op("shr_mod",  OP_SHR, 8'h81, 8'h09, 1'b0);
        run_op("shl_zero", OP_SHL, 8'h81, 8'h08, 1'b0);
        run_op("illegal",  4'hF,   8'hAA, 8'h55, 1'b1);
        run_op("addc",     OP_ADDC, 8'hFF, 8'h00, 1'b1);
        run_op("dec_zero", OP_DEC, 8'h00, 8'h00, 1'b0);

        // Backpressure: let the pending result drain first
        @(negedge clk);
        chk("bp.drained", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        e_add = model(OP_ADD, 8'h12, 8'h34, 1'b0);
        e_xor = model(OP_XOR, 8'hF0, 8'h3C, 1'b0);
        bus.in_valid = 1'b1;  bus.op = OP_ADD;  bus.a = 8'h12;  bus.b = 8'h34;
        @(posedge clk);
        @(negedge clk);
        chk_out("bp.add", e_add);
        bus.op = OP_XOR;  bus.a = 8'hF0;  bus.b = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
            chk_out("bp.hold", e_add);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp.release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk_out("bp.xor", e_xor);

        // Reset during MUL iteration 4
        bus.in_valid = 1'b1;  bus.op = OP_MUL;  bus.a = 8'hD3;  bus.b = 8'h9B;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mulrst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("mulrst.result",    32'(bus.result),    32'd0);
        chk("mulrst.result_hi", 32'(bus.result_hi), 32'd0);
        chk("mulrst.nzcv",      32'(nzcv_now()),    32'd0);
        chk("mulrst.err",       32'(bus.err),       32'd0);
        chk("mulrst.in_ready",  32'(bus.in_ready),  32'd1);
        rst = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            chk("mulrst.no_stale", 32'(bus.out_valid), 32'd0);
        end
        run_op("inc_wrap", OP_INC, 8'hFF, 8'h00, 1'b0);

        // Randomized back-to-back ops at full throughput
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            run_op($sformatf("rnd%0d_op%0h", i, rop), rop,
                   8'($urandom), 8'($urandom), 1'($urandom));
        end

        @(negedge clk);
        chk("final.drained", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
